airi5c_dm_ctrl: RTL and testbench



---
 rtl/airi5c_dm_ctrl_pkg.sv | 44 ++++
 rtl/airi5c_dm_dmi_if.sv | 57 +++++
 rtl/airi5c_dm_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_airi5c_dm_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/airi5c_dm_ctrl_pkg.sv
// Shared constants and types for the airi5c debug-module control stage.
package airi5c_dm_ctrl_pkg;

    localparam int unsigned AddrData0      = 32'h04;
    localparam int unsigned AddrDmControl  = 32'h10;
    localparam int unsigned AddrDmStatus   = 32'h11;
    localparam int unsigned AddrAbstractCs = 32'h16;
    localparam int unsigned AddrCommand    = 32'h17;
    localparam int unsigned AddrProgbuf0   = 32'h20;
    localparam int unsigned AddrProgbuf1   = 32'h21;

    localparam int unsigned DmcHaltReq   = 31;
    localparam int unsigned DmcResumeReq = 30;
    localparam int unsigned DmcNdmReset  = 1;
    localparam int unsigned DmcDmActive  = 0;

    localparam int unsigned AcsCmdErrLo  = 8;
    localparam int unsigned CmdPostExec  = 18;
    localparam int unsigned CmdTransfer  = 17;

    localparam logic [4:0] ProgBufSize = 5'd2;
    localparam logic [3:0] DataCount   = 4'd1;
    localparam logic [3:0] DmVersion   = 4'd2;

    localparam logic [1:0] DmiOpRead  = 2'd1;
    localparam logic [1:0] DmiOpWrite = 2'd2;

    localparam logic [31:0] InsnNop = 32'h0000_0013;

    typedef enum logic [2:0] {
        CmdErrNone       = 3'd0,
        CmdErrBusy       = 3'd1,
        CmdErrNotSup     = 3'd2,
        CmdErrException  = 3'd3,
        CmdErrHaltResume = 3'd4
    } cmderr_e;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StWaitDone
    } cmd_state_e;

endpackage

// File: rtl/airi5c_dm_dmi_if.sv
// DMI request/response handshake: one transaction outstanding, response one
// cycle after acceptance and held until the transport takes it.
module airi5c_dm_dmi_if #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    output logic            accept_o,
    input  logic [XLEN-1:0] rdata_i,
    input  logic            rerr_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_data_o,
    output logic            resp_err_o
);

    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic            resp_err_q, resp_err_d;

    assign req_ready_o = ~resp_valid_q;
    assign accept_o    = req_valid_i & req_ready_o;

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        if (accept_o) begin
            resp_valid_d = 1'b1;
            resp_data_d  = rdata_i;
            resp_err_d   = rerr_i;
        end else if (resp_valid_q && resp_ready_i) begin
            resp_valid_d = 1'b0;
            resp_data_d  = '0;
            resp_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_err_o   = resp_err_q;

endmodule

// File: rtl/airi5c_dm_ctrl.sv
// Debug-module control stage: DMI register file plus the abstract-command
// sequencer that drives the debug ROM's postexec/resume handshake.
module airi5c_dm_ctrl
    import airi5c_dm_ctrl_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DMI_AW = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dmi_req_valid_i,
    output logic              dmi_req_ready_o,
    input  logic [DMI_AW-1:0] dmi_addr_i,
    input  logic [1:0]        dmi_op_i,
    input  logic [XLEN-1:0]   dmi_wdata_i,
    output logic              dmi_resp_valid_o,
    input  logic              dmi_resp_ready_i,
    output logic [XLEN-1:0]   dmi_resp_data_o,
    output logic              dmi_resp_err_o,
    input  logic              halted_i,
    input  logic              resume_ack_i,
    input  logic              exec_done_i,
    output logic              halt_req_o,
    output logic              resume_req_o,
    output logic              postexec_req_o,
    output logic [XLEN-1:0]   progbuf0_o,
    output logic [XLEN-1:0]   progbuf1_o,
    output logic              ndmreset_o
);

    logic            accept;
    logic            dmi_wr;
    logic [31:0]     addr_ext;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] resp_rdata;
    logic            mapped;
    logic            resp_err;
    logic            busy;

    cmd_state_e      state_q, state_d;
    logic            dmactive_q, dmactive_d;
    logic            haltreq_q, haltreq_d;
    logic            ndmreset_q, ndmreset_d;
    logic            resume_req_q, resume_req_d;
    logic [XLEN-1:0] data0_q, data0_d;
    logic [XLEN-1:0] progbuf0_q, progbuf0_d;
    logic [XLEN-1:0] progbuf1_q, progbuf1_d;
    logic [2:0]      cmderr_q, cmderr_d;

    airi5c_dm_dmi_if #(
        .XLEN(XLEN)
    ) u_dmi_if (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (dmi_req_valid_i),
        .req_ready_o  (dmi_req_ready_o),
        .accept_o     (accept),
        .rdata_i      (resp_rdata),
        .rerr_i       (resp_err),
        .resp_valid_o (dmi_resp_valid_o),
        .resp_ready_i (dmi_resp_ready_i),
        .resp_data_o  (dmi_resp_data_o),
        .resp_err_o   (dmi_resp_err_o)
    );

    assign addr_ext = 32'(dmi_addr_i);
    assign dmi_wr   = accept && (dmi_op_i == DmiOpWrite);
    assign busy     = (state_q != StIdle);

    always_comb begin
        rdata  = '0;
        mapped = 1'b1;
        case (addr_ext)
            AddrData0:      rdata = data0_q;
            AddrDmControl:  rdata = {haltreq_q, 29'b0, ndmreset_q, dmactive_q};
            AddrDmStatus:   rdata = {14'b0, {2{resume_ack_i}}, 4'b0, {2{~halted_i}},
                                     {2{halted_i}}, 1'b1, 3'b0, DmVersion};
            AddrAbstractCs: rdata = {3'b0, ProgBufSize, 11'b0, busy, 1'b0, cmderr_q,
                                     4'b0, DataCount};
            AddrCommand:    rdata = '0;
            AddrProgbuf0:   rdata = progbuf0_q;
            AddrProgbuf1:   rdata = progbuf1_q;
            default:        mapped = 1'b0;
        endcase
    end

    assign resp_rdata = (dmi_op_i == DmiOpRead) ? rdata : '0;
    assign resp_err   = ((dmi_op_i == DmiOpRead) || (dmi_op_i == DmiOpWrite)) && !mapped;

    always_comb begin
        state_d      = state_q;
        dmactive_d   = dmactive_q;
        haltreq_d    = haltreq_q;
        ndmreset_d   = ndmreset_q;
        resume_req_d = resume_req_q;
        data0_d      = data0_q;
        progbuf0_d   = progbuf0_q;
        progbuf1_d   = progbuf1_q;
        cmderr_d     = cmderr_q;

        if (resume_req_q && resume_ack_i) begin
            resume_req_d = 1'b0;
        end

        if (dmi_wr) begin
            case (addr_ext)
                AddrDmControl: begin
                    dmactive_d = dmi_wdata_i[DmcDmActive];
                    haltreq_d  = dmi_wdata_i[DmcHaltReq];
                    ndmreset_d = dmi_wdata_i[DmcNdmReset];
                    if (dmi_wdata_i[DmcResumeReq] && !dmi_wdata_i[DmcHaltReq] && halted_i) begin
                        resume_req_d = 1'b1;
                    end
                end
                AddrData0, AddrProgbuf0, AddrProgbuf1, AddrAbstractCs, AddrCommand: begin
                    if (busy) begin
                        if (cmderr_q == CmdErrNone) cmderr_d = CmdErrBusy;
                    end else if (addr_ext == AddrData0) begin
                        data0_d = dmi_wdata_i;
                    end else if (addr_ext == AddrProgbuf0) begin
                        progbuf0_d = dmi_wdata_i;
                    end else if (addr_ext == AddrProgbuf1) begin
                        progbuf1_d = dmi_wdata_i;
                    end else if (addr_ext == AddrAbstractCs) begin
                        cmderr_d = cmderr_q & ~dmi_wdata_i[AcsCmdErrLo +: 3];
                    end else if (cmderr_q != CmdErrNone) begin
                        cmderr_d = cmderr_q;
                    end else if ((|dmi_wdata_i[31:24]) || dmi_wdata_i[CmdTransfer] ||
                                 !dmi_wdata_i[CmdPostExec]) begin
                        cmderr_d = CmdErrNotSup;
                    end else if (!halted_i) begin
                        cmderr_d = CmdErrHaltResume;
                    end else begin
                        state_d = StExec;
                    end
                end
                default: ;
            endcase
        end

        // exec_done wins over a simultaneous halted drop
        case (state_q)
            StExec: state_d = StWaitDone;
            StWaitDone: begin
                if (exec_done_i) begin
                    state_d = StIdle;
                end else if (!halted_i) begin
                    state_d  = StIdle;
                    cmderr_d = CmdErrException;
                end
            end
            default: ;
        endcase

        if (!dmactive_d) begin
            state_d      = StIdle;
            haltreq_d    = 1'b0;
            ndmreset_d   = 1'b0;
            resume_req_d = 1'b0;
            data0_d      = '0;
            progbuf0_d   = InsnNop;
            progbuf1_d   = InsnNop;
            cmderr_d     = CmdErrNone;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dmactive_q   <= 1'b0;
            haltreq_q    <= 1'b0;
            ndmreset_q   <= 1'b0;
            resume_req_q <= 1'b0;
            data0_q      <= '0;
            progbuf0_q   <= InsnNop;
            progbuf1_q   <= InsnNop;
            cmderr_q     <= CmdErrNone;
        end else begin
            dmactive_q   <= dmactive_d;
            haltreq_q    <= haltreq_d;
            ndmreset_q   <= ndmreset_d;
            resume_req_q <= resume_req_d;
            data0_q      <= data0_d;
            progbuf0_q   <= progbuf0_d;
            progbuf1_q   <= progbuf1_d;
            cmderr_q     <= cmderr_d;
        end
    end

    always_comb begin
        halt_req_o     = haltreq_q;
        resume_req_o   = resume_req_q;
        postexec_req_o = (state_q == StExec);
        ndmreset_o     = ndmreset_q;
        progbuf0_o     = progbuf0_q;
        progbuf1_o     = progbuf1_q;
    end

endmodule

// File: tb/tb_airi5c_dm_ctrl.sv
// Bench for airi5c_dm_ctrl: directed walk-through then random DMI traffic,
// responses checked from a queue filled by a behavioural register model.
module tb_airi5c_dm_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        halted;
    logic        resume_ack;
    logic        exec_done;
    logic        halt_req;
    logic        resume_req;
    logic        postexec_req;
    logic [31:0] pb0;
    logic [31:0] pb1;
    logic        ndmreset;

    always #5 clk = ~clk;

    airi5c_dm_ctrl #(
        .XLEN   (32),
        .DMI_AW (7)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .dmi_req_valid_i  (req_valid),
        .dmi_req_ready_o  (req_ready),
        .dmi_addr_i       (addr),
        .dmi_op_i         (op),
        .dmi_wdata_i      (wdata),
        .dmi_resp_valid_o (resp_valid),
        .dmi_resp_ready_i (resp_ready),
        .dmi_resp_data_o  (resp_data),
        .dmi_resp_err_o   (resp_err),
        .halted_i         (halted),
        .resume_ack_i     (resume_ack),
        .exec_done_i      (exec_done),
        .halt_req_o       (halt_req),
        .resume_req_o     (resume_req),
        .postexec_req_o   (postexec_req),
        .progbuf0_o       (pb0),
        .progbuf1_o       (pb1),
        .ndmreset_o       (ndmreset)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          errors  = 0;
    int          acc_cnt = 0;
    bit          chk_en  = 0;

    // Reference model state
    bit          m_active, m_haltreq, m_ndmreset, m_resume;
    bit          m_busy, m_pulse, m_pend;
    logic [31:0] m_data0, m_pb0, m_pb1;
    logic [2:0]  m_cmderr;

    task automatic model_clear();
        m_haltreq  = 0;
        m_ndmreset = 0;
        m_resume   = 0;
        m_busy     = 0;
        m_pulse    = 0;
        m_data0    = 32'h0;
        m_pb0      = 32'h13;
        m_pb1      = 32'h13;
        m_cmderr   = 3'd0;
    endtask

    function automatic bit is_mapped(input int a);
        return a inside {'h04, 'h10, 'h11, 'h16, 'h17, 'h20, 'h21};
    endfunction

    function automatic logic [31:0] read_val(input int a);
        logic [31:0] v;
        v = 32'h0;
        case (a)
            'h04: v = m_data0;
            'h10: v = (32'(m_haltreq) << 31) | (32'(m_ndmreset) << 1) | 32'(m_active);
            'h11: begin
                v = 32'd2 | 32'h80;
                v = v | (halted ? 32'h300 : 32'hC00);
                if (resume_ack) v = v | 32'h30000;
            end
            'h16: v = 32'h0200_0001 | (32'(m_busy) << 12) | (32'(m_cmderr) << 8);
            'h20: v = m_pb0;
            'h21: v = m_pb1;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    task automatic model_write(input int a, input logic [31:0] wd, input bit busy0);
        if (a == 'h10) begin
            m_active   = wd[0];
            m_haltreq  = wd[31];
            m_ndmreset = wd[1];
            if (wd[30] && !wd[31] && halted) m_resume = 1;
        end else if (a inside {'h04, 'h16, 'h17, 'h20, 'h21}) begin
            if (busy0) begin
                if (m_cmderr == 0) m_cmderr = 3'd1;
            end else begin
                case (a)
                    'h04: m_data0 = wd;
                    'h20: m_pb0 = wd;
                    'h21: m_pb1 = wd;
                    'h16: m_cmderr = m_cmderr & ~wd[10:8];
                    default: begin
                        if (m_cmderr != 0) begin
                            m_cmderr = m_cmderr;
                        end else if (wd[31:24] != 0 || wd[17] || !wd[18]) begin
                            m_cmderr = 3'd2;
                        end else if (!halted) begin
                            m_cmderr = 3'd4;
                        end else begin
                            m_busy  = 1;
                            m_pulse = 1;
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic model_step();
        bit   busy0, pulse0, pend0;
        exp_t e;
        if (rst) begin
            m_active = 0;
            m_pend   = 0;
            model_clear();
            exp_q.delete();
            return;
        end
        busy0  = m_busy;
        pulse0 = m_pulse;
        pend0  = m_pend;
        if (m_pend && resp_ready) m_pend = 0;
        if (m_resume && resume_ack) m_resume = 0;
        if (req_valid && !pend0) begin
            e.data = (op == 2'd1) ? read_val(int'(addr)) : 32'h0;
            e.err  = (op == 2'd1 || op == 2'd2) && !is_mapped(int'(addr));
            exp_q.push_back(e);
            m_pend = 1;
            acc_cnt++;
            if (op == 2'd2) model_write(int'(addr), wdata, busy0);
        end
        if (busy0) begin
            if (pulse0) begin
                m_pulse = 0;
            end else if (exec_done) begin
                m_busy = 0;
            end else if (!halted) begin
                m_busy   = 0;
                m_cmderr = 3'd3;
            end
        end
        if (!m_active) model_clear();
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("req_ready", 32'(req_ready), 32'(!m_pend));
                chk("resp_valid", 32'(resp_valid), 32'(m_pend));
                chk("halt_req", 32'(halt_req), 32'(m_haltreq));
                chk("resume_req", 32'(resume_req), 32'(m_resume));
                chk("postexec_req", 32'(postexec_req), 32'(m_pulse));
                chk("ndmreset", 32'(ndmreset), 32'(m_ndmreset));
                chk("progbuf0", pb0, m_pb0);
                chk("progbuf1", pb1, m_pb1);
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            if (chk_en && resp_valid === 1'b1 && resp_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL resp_unexpected: got data %h with no pending request", resp_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_data", resp_data, e.data);
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic dmi(input logic [1:0] o, input logic [6:0] a, input logic [31:0] wd);
        int start;
        start = acc_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        op        = o;
        addr      = a;
        wdata     = wd;
        for (int i = 0; i < 50 && acc_cnt == start; i++) @(negedge clk);
        req_valid = 1'b0;
        if (acc_cnt == start) begin
            vectors++;
            errors++;
            $display("FAIL dmi_accept_timeout: got no acceptance, required one within 50 cycles");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        int          r;
        int          sel;
        logic [6:0]  ra;
        logic [1:0]  ro;
        logic [31:0] rw;
        logic [6:0]  addrs [7];
        addrs = '{7'h04, 7'h10, 7'h11, 7'h16, 7'h17, 7'h20, 7'h21};
        rst        = 1'b1;
        req_valid  = 1'b0;
        addr       = '0;
        op         = '0;
        wdata      = '0;
        halted     = 1'b0;
        resume_ack = 1'b0;
        exec_done  = 1'b0;
        idle(3);
        rst    = 1'b0;
        chk_en = 1;

        dmi(2'd1, 7'h11, 32'h0);
        dmi(2'd1, 7'h16, 32'h0);
        dmi(2'd2, 7'h10, 32'h8000_0001);
        idle(2);
        halted = 1'b1;
        idle(1);
        dmi(2'd1, 7'h11, 32'h0);
        dmi(2'd2, 7'h20, 32'h0010_0513);
        dmi(2'd2, 7'h17, 32'h0004_0000);
        dmi(2'd1, 7'h16, 32'h0);
        dmi(2'd2, 7'h21, 32'h1234_5678);
        dmi(2'd2, 7'h17, 32'h0004_0000);
        dmi(2'd1, 7'h21, 32'h0);
        dmi(2'd1, 7'h16, 32'h0);
        pulse_done();
        idle(1);
        dmi(2'd1, 7'h16, 32'h0);
        dmi(2'd2, 7'h16, 32'h0000_0700);
        dmi(2'd1, 7'h16, 32'h0);
        dmi(2'd2, 7'h17, 32'h0002_0000);
        dmi(2'd1, 7'h16, 32'h0);
        dmi(2'd2, 7'h16, 32'h0000_0700);
        halted = 1'b0;
        dmi(2'd2, 7'h17, 32'h0004_0000);
        dmi(2'd1, 7'h16, 32'h0);
        dmi(2'd2, 7'h16, 32'h0000_0700);
        halted = 1'b1;
        dmi(2'd2, 7'h10, 32'h4000_0001);
        idle(2);
        resume_ack = 1'b1;
        idle(1);
        resume_ack = 1'b0;
        idle(1);
        dmi(2'd2, 7'h10, 32'h8000_0003);
        dmi(2'd2, 7'h17, 32'h0004_0000);
        idle(2);
        do_reset();
        idle(1);
        dmi(2'd1, 7'h7F, 32'h0);
        dmi(2'd2, 7'h10, 32'h0000_0001);

        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 15);
            if (r < 9) begin
                sel = $urandom_range(0, 7);
                ra  = (sel == 7) ? 7'($urandom_range(0, 127)) : addrs[sel];
                ro  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3))
                                                  : 2'($urandom_range(1, 2));
                rw  = $urandom;
                if (ra == 7'h17) begin
                    case ($urandom_range(0, 3))
                        0, 1: rw = 32'h0004_0000;
                        2:    rw = 32'h0002_0000;
                        default: rw = 32'h0104_0000;
                    endcase
                end else if (ra == 7'h10) begin
                    rw = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 28'h0,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) != 0)};
                end else if (ra == 7'h16) begin
                    rw = {21'h0, 3'($urandom_range(0, 7)), 8'h0};
                end
                dmi(ro, ra, rw);
            end else if (r < 11) begin
                pulse_done();
            end else if (r < 13) begin
                @(negedge clk);
                halted = ~halted;
            end else if (r < 15) begin
                @(negedge clk);
                resume_ack = ~resume_ack;
            end else if ($urandom_range(0, 4) == 0) begin
                do_reset();
            end else begin
                idle(1);
            end
        end
        idle(10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
